dmem_responder: RTL and testbench

- Responder end of the core data-memory port (addr/data/req/we/sel/ack/exception).
- Sits between a core's MEM&WB stage and on-chip word storage. It can serve as the memory model in core-level benches, or as a small scratchpad in the SoC.
- Accepts one request at a time, inserts a programmable number of wait states, then returns a single-cycle ack with read data or an exception.

---
 rtl/dmem_responder_pkg.sv | 37 +++
 rtl/dmem_responder_array.sv | 47 ++++
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types for the data-memory responder
//
// Purpose : FSM state type and wait-counter width for dmem_responder.
//           Also provides default values for the `RW word width and the
//           `ADDR_BYTES byte-enable width when no config file set them.
// Ports   : none (package).
// Options : DMEM_RESP_INIT_CLEAR_EN adds the INIT state used by the
//           post-reset clearing sweep.
`ifndef RW
`define RW 16
`endif
`ifndef ADDR_BYTES
`define ADDR_BYTES 2
`endif

package dmem_responder_pkg;

    localparam int CNT_W = 4;

`ifdef DMEM_RESP_INIT_CLEAR_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_TURN,
        S_INIT
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_TURN
    } state_e;
`endif

endpackage

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - single-port word storage with byte enables
//
// Purpose : DEPTH x `RW synchronous single-port array, per-byte write
//           enable, registered read (old data on a write cycle). Kept as its
//           own module so it can be swapped for an SRAM macro.
// Ports   : i_clk    clock
//           i_we     write strobe
//           i_be     byte enables, bit b covers [8b+7:8b]
//           i_addr   word index
//           i_wdata  write data
//           o_rdata  registered read data for the previous cycle's i_addr
`ifndef RW
`define RW 16
`endif
`ifndef ADDR_BYTES
`define ADDR_BYTES 2
`endif

module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [`ADDR_BYTES-1:0] i_be,
    input  logic [AW-1:0]          i_addr,
    input  logic [`RW-1:0]         i_wdata,
    output logic [`RW-1:0]         o_rdata
);

    logic [`RW-1:0] mem_q [DEPTH];
    logic [`RW-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < `ADDR_BYTES; b++) begin
                if (i_be[b]) begin
                    mem_q[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - responder end of the core data-memory port
//
// Purpose : Accepts one request at a time, waits WAIT_CYCLES states, then
//           returns a one-cycle ack with read data or an out-of-range
//           exception. A TURN cycle after every ack ignores i_mem_req so a
//           master dropping req late is not served twice.
// Ports   : i_clk, i_rst        clock, synchronous active-high reset
//           i_mem_req/we        request valid (held until ack), write select
//           i_mem_addr/data     word address, write data
//           i_mem_sel           byte enables
//           o_mem_data          read data, non-zero only during the ack
//           o_mem_ack           one-cycle completion pulse
//           o_mem_exception     with ack when the address is >= DEPTH
//           o_busy              access in flight or clearing sweep running
// Options : DMEM_RESP_INIT_CLEAR_EN - after reset, sweep zeros into every
//           word (one per cycle) before accepting requests.
`ifndef RW
`define RW 16
`endif
`ifndef ADDR_BYTES
`define ADDR_BYTES 2
`endif

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_mem_req,
    input  logic                   i_mem_we,
    input  logic [`RW-1:0]         i_mem_addr,
    input  logic [`RW-1:0]         i_mem_data,
    input  logic [`ADDR_BYTES-1:0] i_mem_sel,
    output logic [`RW-1:0]         o_mem_data,
    output logic                   o_mem_ack,
    output logic                   o_mem_exception,
    output logic                   o_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [`RW:0] DEPTH_X = (`RW+1)'(DEPTH);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;
    logic [`RW-1:0]         addr_q;
    logic [`RW-1:0]         data_q;
    logic [`ADDR_BYTES-1:0] sel_q;
    logic                   busy_q;
    logic                   ack_q;
    logic                   exc_q;
    logic                   rd_ok_q;
`ifdef DMEM_RESP_INIT_CLEAR_EN
    logic [AW-1:0]          init_q;
`endif

    // The access that RESP will serve: straight from the port when it is
    // accepted with zero wait states, otherwise the latched copy.
    logic [`RW-1:0] acc_addr_d;
    logic           acc_we_d;
    logic           acc_ok_d;
    logic           go_resp_d;
    logic           resp_ok;

    logic                   arr_we;
    logic [AW-1:0]          arr_addr;
    logic [`ADDR_BYTES-1:0] arr_be;
    logic [`RW-1:0]         arr_wdata;
    logic [`RW-1:0]         arr_rdata;

    always_comb begin
        acc_addr_d = (state_q == S_IDLE) ? i_mem_addr : addr_q;
        acc_we_d   = (state_q == S_IDLE) ? i_mem_we   : we_q;
        acc_ok_d   = {1'b0, acc_addr_d} < DEPTH_X;
        go_resp_d  = ((state_q == S_IDLE) && i_mem_req && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == '0));
        resp_ok    = {1'b0, addr_q} < DEPTH_X;
    end

    // The array is read every cycle at acc_addr_d, so the word is in its
    // output register exactly when RESP begins. Writes commit on the edge
    // that ends RESP; qualifying with !i_rst keeps a reset on that edge from
    // committing an access that is being discarded.
    always_comb begin
        arr_we    = (state_q == S_RESP) && we_q && resp_ok && !i_rst;
        arr_addr  = acc_addr_d[AW-1:0];
        arr_be    = sel_q;
        arr_wdata = data_q;
`ifdef DMEM_RESP_INIT_CLEAR_EN
        if (state_q == S_INIT) begin
            arr_we    = !i_rst;
            arr_addr  = init_q;
            arr_be    = '1;
            arr_wdata = '0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
`ifdef DMEM_RESP_INIT_CLEAR_EN
            state_q <= S_INIT;
            busy_q  <= 1'b1;
            init_q  <= '0;
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            exc_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            exc_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            if (go_resp_d) begin
                ack_q   <= 1'b1;
                exc_q   <= !acc_ok_d;
                rd_ok_q <= acc_ok_d && !acc_we_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_mem_req) begin
                        we_q   <= i_mem_we;
                        addr_q <= i_mem_addr;
                        data_q <= i_mem_data;
                        sel_q  <= i_mem_sel;
                        busy_q <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_TURN;
                end
                S_TURN: begin
                    state_q <= S_IDLE;
                end
`ifdef DMEM_RESP_INIT_CLEAR_EN
                S_INIT: begin
                    init_q <= init_q + 1'b1;
                    if (init_q == AW'(DEPTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (arr_we),
        .i_be    (arr_be),
        .i_addr  (arr_addr),
        .i_wdata (arr_wdata),
        .o_rdata (arr_rdata)
    );

    assign o_mem_data      = rd_ok_q ? arr_rdata : '0;
    assign o_mem_ack       = ack_q;
    assign o_mem_exception = exc_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
`ifndef RW
`define RW 16
`endif
`ifndef ADDR_BYTES
`define ADDR_BYTES 2
`endif

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req1 = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [1:0]  sel = 2'b00;

    logic [15:0] d1, d3;
    logic        ack1, ack3, exc1, exc3, busy1, busy3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_mem_req(req1), .i_mem_we(we),
        .i_mem_addr(addr), .i_mem_data(wdata), .i_mem_sel(sel),
        .o_mem_data(d1), .o_mem_ack(ack1), .o_mem_exception(exc1), .o_busy(busy1)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_mem_req(req3), .i_mem_we(we),
        .i_mem_addr(addr), .i_mem_data(wdata), .i_mem_sel(sel),
        .o_mem_data(d3), .o_mem_ack(ack3), .o_mem_exception(exc3), .o_busy(busy3)
    );

    // Issue one access to dut1 (which=1) or dut3 (which=3), starting with the
    // DUT idle. n = edges from raising req to the ack (-1 on timeout).
    // Leaves the DUT idle again (past TURN) on return.
    task automatic access(input int which, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] s,
                          output logic [15:0] rd, output logic ex, output int n);
        we = w; addr = a; wdata = d; sel = s;
        if (which == 3) req3 = 1'b1; else req1 = 1'b1;
        n = -1; rd = 16'hxxxx; ex = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((which == 3) ? ack3 : ack1) begin
                n  = i;
                rd = (which == 3) ? d3 : d1;
                ex = (which == 3) ? exc3 : exc1;
                break;
            end
        end
        req1 = 1'b0; req3 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (ack1 !== 1'b0 || exc1 !== 1'b0 || d1 !== 16'h0) begin
            nerr++;
            $display("FAIL reset_outputs: ack=%b exc=%b data=%h, required 0 0 0000", ack1, exc1, d1);
        end
        nvec++;
`ifdef DMEM_RESP_INIT_CLEAR_EN
        if (busy1 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_busy: busy=%b, required 1", busy1);
        end
`else
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy: busy=%b/%b, required 0/0", busy1, busy3);
        end
`endif
        rst = 1'b0;
`ifdef DMEM_RESP_INIT_CLEAR_EN
        repeat (300) @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_write_read();
        logic [15:0] rd; logic ex; int n;
        access(1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, rd, ex, n);
        nvec++;
        if (n !== 2 || ex !== 1'b0 || rd !== 16'h0000) begin
            nerr++;
            $display("FAIL wr_beef: lat=%0d exc=%b data=%h, required 2 0 0000", n, ex, rd);
        end
        access(1, 1'b0, 16'h0010, 16'h0000, 2'b00, rd, ex, n);
        nvec++;
        if (n !== 2 || ex !== 1'b0 || rd !== 16'hBEEF) begin
            nerr++;
            $display("FAIL rd_beef: lat=%0d exc=%b data=%h, required 2 0 beef", n, ex, rd);
        end
    endtask

    task automatic test_byte_select();
        logic [15:0] rd; logic ex; int n;
        access(1, 1'b1, 16'h0010, 16'h1234, 2'b01, rd, ex, n);
        access(1, 1'b0, 16'h0010, 16'h0000, 2'b11, rd, ex, n);
        nvec++;
        if (rd !== 16'hBE34) begin
            nerr++;
            $display("FAIL sel01: data=%h, required be34", rd);
        end
        access(1, 1'b1, 16'h0010, 16'hFFFF, 2'b00, rd, ex, n);
        nvec++;
        if (n !== 2 || ex !== 1'b0) begin
            nerr++;
            $display("FAIL sel00_ack: lat=%0d exc=%b, required 2 0", n, ex);
        end
        access(1, 1'b0, 16'h0010, 16'h0000, 2'b00, rd, ex, n);
        nvec++;
        if (rd !== 16'hBE34) begin
            nerr++;
            $display("FAIL sel00_keep: data=%h, required be34", rd);
        end
        access(1, 1'b1, 16'h0010, 16'hAB00, 2'b10, rd, ex, n);
        access(1, 1'b0, 16'h0010, 16'h0000, 2'b01, rd, ex, n);
        nvec++;
        if (rd !== 16'hAB34) begin
            nerr++;
            $display("FAIL sel10: data=%h, required ab34", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd; logic ex; int n;
        access(1, 1'b1, 16'h0000, 16'h0F0F, 2'b11, rd, ex, n);
        access(1, 1'b1, 16'h00FF, 16'h5A5A, 2'b11, rd, ex, n);
        nvec++;
        if (ex !== 1'b0) begin
            nerr++;
            $display("FAIL wr_last_word: exc=%b, required 0", ex);
        end
        access(1, 1'b0, 16'h0100, 16'h0000, 2'b11, rd, ex, n);
        nvec++;
        if (n !== 2 || ex !== 1'b1 || rd !== 16'h0000) begin
            nerr++;
            $display("FAIL rd_0100: lat=%0d exc=%b data=%h, required 2 1 0000", n, ex, rd);
        end
        access(1, 1'b1, 16'hFFFF, 16'hDEAD, 2'b11, rd, ex, n);
        nvec++;
        if (n !== 2 || ex !== 1'b1) begin
            nerr++;
            $display("FAIL wr_ffff: lat=%0d exc=%b, required 2 1", n, ex);
        end
        access(1, 1'b1, 16'h0100, 16'hDEAD, 2'b11, rd, ex, n);
        nvec++;
        if (ex !== 1'b1) begin
            nerr++;
            $display("FAIL wr_0100: exc=%b, required 1", ex);
        end
        access(1, 1'b0, 16'h00FF, 16'h0000, 2'b11, rd, ex, n);
        nvec++;
        if (ex !== 1'b0 || rd !== 16'h5A5A) begin
            nerr++;
            $display("FAIL keep_00ff: exc=%b data=%h, required 0 5a5a", ex, rd);
        end
        access(1, 1'b0, 16'h0000, 16'h0000, 2'b11, rd, ex, n);
        nvec++;
        if (rd !== 16'h0F0F) begin
            nerr++;
            $display("FAIL keep_0000: data=%h, required 0f0f", rd);
        end
    endtask

    task automatic test_held_request();
        int first = -1;
        int second = -1;
        logic [15:0] rd2 = 16'h0;
        we = 1'b0; addr = 16'h0010; sel = 2'b11;
        req1 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (ack1) begin
                if (first < 0) begin
                    first = i;
                end else begin
                    second = i;
                    rd2 = d1;
                    break;
                end
            end
        end
        req1 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        nvec++;
        if (first !== 2 || second !== 6) begin
            nerr++;
            $display("FAIL held_req: acks at %0d,%0d, required 2,6", first, second);
        end
        nvec++;
        if (rd2 !== 16'hAB34) begin
            nerr++;
            $display("FAIL held_req_data: data=%h, required ab34", rd2);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd; logic ex; int n;
        logic seen_ack = 1'b0;
        access(3, 1'b1, 16'h0005, 16'h1111, 2'b11, rd, ex, n);
        nvec++;
        if (n !== 4 || ex !== 1'b0) begin
            nerr++;
            $display("FAIL w3_latency: lat=%0d exc=%b, required 4 0", n, ex);
        end
        we = 1'b1; addr = 16'h0005; wdata = 16'h2222; sel = 2'b11;
        req3 = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack3) seen_ack = 1'b1;
        end
        rst = 1'b1; req3 = 1'b0;
        @(posedge clk); #1;
        if (ack3) seen_ack = 1'b1;
        nvec++;
        if (seen_ack !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_ack: ack seen=%b, required 0", seen_ack);
        end
        nvec++;
`ifdef DMEM_RESP_INIT_CLEAR_EN
        if (busy3 !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_busy: busy=%b, required 1", busy3);
        end
`else
        if (busy3 !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_busy: busy=%b, required 0", busy3);
        end
`endif
        rst = 1'b0;
`ifdef DMEM_RESP_INIT_CLEAR_EN
        repeat (300) @(posedge clk);
        #1;
`endif
        access(3, 1'b0, 16'h0005, 16'h0000, 2'b11, rd, ex, n);
        nvec++;
`ifdef DMEM_RESP_INIT_CLEAR_EN
        if (rd !== 16'h0000) begin
            nerr++;
            $display("FAIL rst_mid_keep: data=%h, required 0000", rd);
        end
`else
        if (rd !== 16'h1111) begin
            nerr++;
            $display("FAIL rst_mid_keep: data=%h, required 1111", rd);
        end
`endif
    endtask

`ifdef DMEM_RESP_INIT_CLEAR_EN
    task automatic test_init_sweep();
        int n = -1;
        logic [15:0] rd = 16'hxxxx;
        logic busy_start;
        rst = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; addr = 16'h0010; sel = 2'b11;
        rst = 1'b0; req1 = 1'b1;
        @(posedge clk); #1;
        busy_start = busy1;
        if (ack1) n = 1;
        for (int i = 2; i <= 400 && n < 0; i++) begin
            @(posedge clk); #1;
            if (ack1) begin
                n = i;
                rd = d1;
            end
        end
        req1 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        nvec++;
        if (busy_start !== 1'b1) begin
            nerr++;
            $display("FAIL init_busy: busy=%b, required 1", busy_start);
        end
        nvec++;
        if (n !== 258 || rd !== 16'h0000) begin
            nerr++;
            $display("FAIL init_ack: ack edge=%0d data=%h, required 258 0000", n, rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_select();
        test_out_of_range();
        test_held_request();
        test_reset_mid_access();
`ifdef DMEM_RESP_INIT_CLEAR_EN
        test_init_sweep();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
